// File: rtl/prime_check_pkg.sv
// Shared constants for the prime_check trial-division tester.
package prime_check_pkg;

   // Controller state encodings (2-bit, kept as plain constants).
   localparam logic [1:0] PC_IDLE  = 2'd0;
   localparam logic [1:0] PC_ISSUE = 2'd1;
   localparam logic [1:0] PC_WAIT  = 2'd2;

   // First divisor tried for every candidate.
   localparam int FIRST_DIVISOR = 2;

endpackage

// File: rtl/prime_check_divmod.sv
// Restoring unsigned divider with a go/ready/error handshake.
// One quotient bit per cycle; ready is registered and drops the cycle after go.
module prime_check_divmod #(
   parameter int WIDTH_LOG = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        go,
   input  logic [(1<<WIDTH_LOG)-1:0]   a,
   input  logic [(1<<WIDTH_LOG)-1:0]   b,
   output logic                        ready,
   output logic [(1<<WIDTH_LOG)-1:0]   div,
   output logic [(1<<WIDTH_LOG)-1:0]   mod,
   output logic                        error
);
   import prime_check_pkg::*;

   localparam int WIDTH = 1 << WIDTH_LOG;

   logic                 ready_reg;
   logic                 error_reg;
   logic [WIDTH-1:0]     quo_reg;
   logic [WIDTH-1:0]     rem_reg;
   logic [WIDTH-1:0]     den_reg;
   logic [WIDTH_LOG-1:0] count_reg;

   logic [WIDTH:0]       rem_shift;
   logic                 fits;
   logic [WIDTH-1:0]     rem_next;
   logic [WIDTH-1:0]     quo_next;

   // One restoring step: shift in the next dividend bit, subtract if it fits.
   always_comb begin
      rem_shift = {rem_reg, quo_reg[WIDTH-1]};
      fits      = (rem_shift >= {1'b0, den_reg});
      rem_next  = fits ? WIDTH'(rem_shift - {1'b0, den_reg}) : rem_shift[WIDTH-1:0];
      quo_next  = {quo_reg[WIDTH-2:0], fits};
   end

   // Accept a request when idle, then iterate WIDTH steps before raising ready.
   always_ff @(posedge clk) begin
      if (rst) begin
         ready_reg <= 1'b1;
         error_reg <= 1'b0;
         quo_reg   <= '0;
         rem_reg   <= '0;
         den_reg   <= '0;
         count_reg <= '0;
      end else if (ready_reg) begin
         if (go) begin
            ready_reg <= 1'b0;
            error_reg <= (b == '0);
            quo_reg   <= a;
            rem_reg   <= '0;
            den_reg   <= b;
            count_reg <= '0;
         end
      end else begin
         quo_reg   <= quo_next;
         rem_reg   <= rem_next;
         count_reg <= count_reg + 1'b1;
         if (count_reg == WIDTH_LOG'(WIDTH - 1)) begin
            ready_reg <= 1'b1;
         end
      end
   end

   assign ready = ready_reg;
   assign error = error_reg;
   assign div   = quo_reg;
   assign mod   = rem_reg;

endmodule

// File: rtl/prime_check.sv
// Trial-division primality tester driving an embedded divmod.
// Tries d = 2, 3, 5, 7, ... and stops when n/d < d (prime) or n%d == 0.
module prime_check #(
   parameter int WIDTH_LOG = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        go,
   input  logic [(1<<WIDTH_LOG)-1:0]   n,
   output logic                        ready,
   output logic                        is_prime,
   output logic [(1<<WIDTH_LOG)-1:0]   factor,
   output logic                        error
);
   import prime_check_pkg::*;

   localparam int WIDTH = 1 << WIDTH_LOG;

   logic [1:0]       state_reg;
   logic [WIDTH-1:0] n_reg;
   logic [WIDTH-1:0] d_reg;
   logic             ready_reg;
   logic             is_prime_reg;
   logic [WIDTH-1:0] factor_reg;
   logic             error_reg;

   logic             dm_go;
   logic [WIDTH-1:0] dm_a;
   logic [WIDTH-1:0] dm_b;
   logic             dm_ready;
   logic [WIDTH-1:0] dm_div;
   logic [WIDTH-1:0] dm_mod;
   logic             dm_error;

   // Operands come straight from registers, so they stay stable through WAIT.
   assign dm_go = (state_reg == PC_ISSUE);
   assign dm_a  = n_reg;
   assign dm_b  = d_reg;

   prime_check_divmod #(
      .WIDTH_LOG (WIDTH_LOG)
   ) u_divmod (
      .clk   (clk),
      .rst   (rst),
      .go    (dm_go),
      .a     (dm_a),
      .b     (dm_b),
      .ready (dm_ready),
      .div   (dm_div),
      .mod   (dm_mod),
      .error (dm_error)
   );

   // Controller: accept a candidate, issue one division per divisor, decide.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= PC_IDLE;
         n_reg        <= '0;
         d_reg        <= '0;
         ready_reg    <= 1'b1;
         is_prime_reg <= 1'b0;
         factor_reg   <= '0;
         error_reg    <= 1'b0;
      end else begin
         case (state_reg)
            PC_IDLE: begin
               if (go) begin
                  n_reg <= n;
                  if (n < WIDTH'(2)) begin
                     is_prime_reg <= 1'b0;
                     factor_reg   <= '0;
                  end else begin
                     d_reg     <= WIDTH'(FIRST_DIVISOR);
                     ready_reg <= 1'b0;
                     state_reg <= PC_ISSUE;
                  end
               end
            end
            PC_ISSUE: begin
               state_reg <= PC_WAIT;
            end
            PC_WAIT: begin
               if (dm_ready) begin
                  if (dm_error) begin
                     error_reg    <= 1'b1;
                     is_prime_reg <= 1'b0;
                     factor_reg   <= '0;
                     ready_reg    <= 1'b1;
                     state_reg    <= PC_IDLE;
                  end else if (dm_div < d_reg) begin
                     // d*d > n: no factor left below sqrt(n). Also covers n == d.
                     is_prime_reg <= 1'b1;
                     factor_reg   <= n_reg;
                     ready_reg    <= 1'b1;
                     state_reg    <= PC_IDLE;
                  end else if (dm_mod == '0) begin
                     is_prime_reg <= 1'b0;
                     factor_reg   <= d_reg;
                     ready_reg    <= 1'b1;
                     state_reg    <= PC_IDLE;
                  end else begin
                     d_reg     <= (d_reg == WIDTH'(2)) ? WIDTH'(3) : d_reg + WIDTH'(2);
                     state_reg <= PC_ISSUE;
                  end
               end
            end
            default: begin
               state_reg <= PC_IDLE;
               ready_reg <= 1'b1;
            end
         endcase
      end
   end

   assign ready    = ready_reg;
   assign is_prime = is_prime_reg;
   assign factor   = factor_reg;
   assign error    = error_reg;

endmodule

// File: tb/tb_prime_check.sv
// Self-checking bench for prime_check: fixed and random candidates against a
// plain-arithmetic smallest-factor model, plus busy-go and mid-run reset.
module tb_prime_check;

   localparam int WIDTH_LOG = 4;
   localparam int WIDTH     = 1 << WIDTH_LOG;
   localparam int MAX_WAIT  = 5000;

   logic             clk;
   logic             rst;
   logic             go;
   logic [WIDTH-1:0] n;
   logic             ready;
   logic             is_prime;
   logic [WIDTH-1:0] factor;
   logic             error;

   int total_checks = 0;
   int pass_checks  = 0;

   logic             ready_after_go;
   logic [WIDTH-1:0] issued[$];

   prime_check #(
      .WIDTH_LOG (WIDTH_LOG)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .go       (go),
      .n        (n),
      .ready    (ready),
      .is_prime (is_prime),
      .factor   (factor),
      .error    (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every divisor handed to the divider.
   always @(posedge clk) begin
      if (!rst && dut.dm_go) issued.push_back(dut.dm_b);
   end

   // Reference: smallest prime factor by plain trial division (0 for n<2).
   function automatic int ref_factor(input int v);
      if (v < 2) return 0;
      for (int f = 2; f * f <= v; f++) begin
         if (v % f == 0) return f;
      end
      return v;
   endfunction

   // Start one run from idle (called #1 after an edge) and wait for ready.
   task automatic run_n(input logic [WIDTH-1:0] val, output int cycles, output bit timed_out);
      issued.delete();
      go = 1'b1;
      n  = val;
      @(posedge clk); #1;
      go = 1'b0;
      ready_after_go = ready;
      cycles    = 0;
      timed_out = 1'b0;
      while (ready !== 1'b1) begin
         if (cycles >= MAX_WAIT) begin
            timed_out = 1'b1;
            break;
         end
         @(posedge clk); #1;
         cycles++;
      end
      $display("run n=%0d is_prime=%0b factor=%0d cycles=%0d divisions=%0d",
               val, is_prime, factor, cycles, issued.size());
   endtask

   // Check one finished run against the model.
   task automatic check_result(input string tag, input int v, input bit timed_out);
      int  exp_f;
      bit  exp_p;
      exp_f = ref_factor(v);
      exp_p = (v >= 2) && (exp_f == v);
      total_checks++;
      if (timed_out) $display("FAIL %s timeout: ready=%0b required 1 within %0d cycles", tag, ready, MAX_WAIT);
      else pass_checks++;
      total_checks++;
      if (is_prime !== exp_p) $display("FAIL %s is_prime: got %0b required %0b (n=%0d)", tag, is_prime, exp_p, v);
      else pass_checks++;
      total_checks++;
      if (factor !== WIDTH'(exp_f)) $display("FAIL %s factor: got %0d required %0d (n=%0d)", tag, factor, exp_f, v);
      else pass_checks++;
      total_checks++;
      if (ready_after_go !== (v < 2 ? 1'b1 : 1'b0))
         $display("FAIL %s ready_after_go: got %0b required %0b (n=%0d)", tag, ready_after_go, v < 2, v);
      else pass_checks++;
   endtask

   task automatic test_reset();
      rst = 1'b1; go = 1'b0; n = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      total_checks++;
      if ({ready, is_prime, factor, error} !== {1'b1, 1'b0, 16'd0, 1'b0})
         $display("FAIL reset: ready=%0b is_prime=%0b factor=%0d error=%0b required 1 0 0 0", ready, is_prime, factor, error);
      else pass_checks++;
   endtask

   task automatic test_small();
      int  cyc;
      bit  to;
      for (int v = 0; v < 2; v++) begin
         run_n(16'd7, cyc, to);   // leave a nonzero result behind first
         run_n(WIDTH'(v), cyc, to);
         check_result("small", v, to);
         total_checks++;
         if (cyc !== 0) $display("FAIL small_latency: got %0d cycles required 0 (n=%0d)", cyc, v);
         else pass_checks++;
      end
   endtask

   task automatic test_fixed();
      int  vals[10] = '{2, 4, 9, 25, 97, 65521, 65535, 65281, 63001, 3};
      int  cyc;
      bit  to;
      foreach (vals[i]) begin
         run_n(WIDTH'(vals[i]), cyc, to);
         check_result("fixed", vals[i], to);
         if (vals[i] == 2) begin
            total_checks++;
            if (issued.size() !== 1) $display("FAIL n2_divisions: got %0d required 1", issued.size());
            else pass_checks++;
         end
         if (vals[i] == 9) begin
            total_checks++;
            if (issued.size() !== 2 || issued[0] !== 16'd2 || issued[1] !== 16'd3)
               $display("FAIL n9_divisors: got count %0d required divisors 2,3", issued.size());
            else pass_checks++;
         end
         if (vals[i] == 63001) begin
            total_checks++;
            if (factor !== 16'd251) $display("FAIL n63001_factor: got %0d required 251", factor);
            else pass_checks++;
         end
         if (vals[i] >= 2 && !to) begin
            // Composite: the last divisor tried is the smallest factor.
            total_checks++;
            if (ref_factor(vals[i]) != vals[i] && issued[$] !== WIDTH'(ref_factor(vals[i])))
               $display("FAIL last_divisor: got %0d required %0d (n=%0d)", issued[$], ref_factor(vals[i]), vals[i]);
            else pass_checks++;
         end
      end
   endtask

   task automatic test_random();
      int  v;
      int  cyc;
      bit  to;
      for (int i = 0; i < 16; i++) begin
         v = (i < 8) ? int'($urandom_range(0, 400)) : int'($urandom_range(2, 65535));
         run_n(WIDTH'(v), cyc, to);
         check_result("random", v, to);
      end
   endtask

   task automatic test_hold();
      logic [WIDTH-1:0] keep;
      int  cyc;
      bit  to;
      run_n(16'd221, cyc, to);   // 13*17
      keep = factor;
      go = 1'b0;
      repeat (5) begin
         n = WIDTH'($urandom);
         @(posedge clk); #1;
      end
      total_checks++;
      if (factor !== 16'd13 || is_prime !== 1'b0 || ready !== 1'b1)
         $display("FAIL hold: factor=%0d is_prime=%0b ready=%0b required 13 0 1 (was %0d)", factor, is_prime, ready, keep);
      else pass_checks++;
   endtask

   task automatic test_busy_go();
      int cyc;
      go = 1'b1; n = 16'd97;
      @(posedge clk); #1;
      go = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      go = 1'b1; n = 16'd4;
      @(posedge clk); #1;
      go = 1'b0; n = '0;
      cyc = 0;
      while (ready !== 1'b1 && cyc < MAX_WAIT) begin
         @(posedge clk); #1;
         cyc++;
      end
      $display("run n=97 (go n=4 while busy) is_prime=%0b factor=%0d cycles=%0d", is_prime, factor, cyc);
      total_checks++;
      if (ready !== 1'b1 || is_prime !== 1'b1 || factor !== 16'd97)
         $display("FAIL busy_go: ready=%0b is_prime=%0b factor=%0d required 1 1 97", ready, is_prime, factor);
      else pass_checks++;
   endtask

   task automatic test_rst_mid();
      int cyc;
      bit to;
      go = 1'b1; n = 16'd97;
      @(posedge clk); #1;
      go = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      $display("run n=97 aborted by rst: ready=%0b is_prime=%0b factor=%0d error=%0b", ready, is_prime, factor, error);
      total_checks++;
      if ({ready, is_prime, factor, error} !== {1'b1, 1'b0, 16'd0, 1'b0})
         $display("FAIL rst_mid: ready=%0b is_prime=%0b factor=%0d error=%0b required 1 0 0 0", ready, is_prime, factor, error);
      else pass_checks++;
      run_n(16'd15, cyc, to);
      check_result("after_rst", 15, to);
      total_checks++;
      if (error !== 1'b0) $display("FAIL error_flag: got %0b required 0", error);
      else pass_checks++;
   endtask

   initial begin
      test_reset();
      test_small();
      test_fixed();
      test_random();
      test_hold();
      test_busy_go();
      test_rst_mid();
      $display("%0d/%0d checks passed", pass_checks, total_checks);
      $finish;
   end

endmodule
